// File: rtl/isa_dma_sample_sink.sv
// XT-bus I/O responder that takes 8-bit samples from CPU port writes or single-mode 8237 DMA,
// buffers them in a FIFO and replays them onto sample_out at a programmable rate.
module isa_dma_sample_sink #(
  parameter logic [9:0]  IO_BASE     = 10'h2C0,
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned DREQ_LEVEL  = 12
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [19:0] address,
  input  logic [7:0]  internal_data_bus,
  output logic [7:0]  data_bus_out,
  output logic        data_bus_out_enable,
  input  logic        io_read_n,
  input  logic        io_write_n,
  input  logic        address_enable_n,
  output logic        dma_request,
  input  logic        dma_acknowledge_n,
  input  logic        terminal_count_n,
  output logic        io_channel_ready,
  output logic        interrupt_request,
  output logic [7:0]  sample_out,
  output logic        sample_strobe
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [2:0]    WS_LOAD  = 3'(WAIT_STATES);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] DREQ_CNT = CW'(DREQ_LEVEL);

  logic          ior_q, ior_d, iow_q, iow_d;
  logic [2:0]    ws_q, ws_d;
  logic [7:0]    dout_q, dout_d;
  logic          dma_en_q, dma_en_d, irq_en_q, irq_en_d, irq_q, irq_d;
  logic          overrun_q, overrun_d, tc_seen_q, tc_seen_d;
  logic [15:0]   rate_div_q, rate_div_d, rc_q, rc_d;
  logic          dreq_q, dreq_d, pending_q, pending_d;
  logic [7:0]    sample_q, sample_d;
  logic          strobe_q, strobe_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];

  logic       cpu_sel, dma_sel, ior_fall, ior_rise, iow_fall, iow_rise;
  logic       access_start, cpu_rd_start, status_rd_end, cpu_wr, dma_wr;
  logic       flush, push_req, tc_hit, pop_en, push_en;
  logic [1:0] reg_sel;
  logic [7:0] rd_mux;
  logic       addr_hi_unused;

  // The upper address lines take no part in an XT I/O decode.
  assign addr_hi_unused = ^address[19:10];

  // Bus decode and strobe edge detection against the registered strobes.
  always_comb begin
    reg_sel       = address[1:0];
    cpu_sel       = address_enable_n & (address[9:2] == IO_BASE[9:2]);
    dma_sel       = ~dma_acknowledge_n;
    ior_fall      = ior_q & ~io_read_n;
    ior_rise      = ~ior_q & io_read_n;
    iow_fall      = iow_q & ~io_write_n;
    iow_rise      = ~iow_q & io_write_n;
    access_start  = (cpu_sel & (ior_fall | iow_fall)) | (dma_sel & iow_fall);
    cpu_rd_start  = cpu_sel & ior_fall;
    status_rd_end = cpu_sel & ior_rise & (reg_sel == 2'd0);
    cpu_wr        = cpu_sel & dma_acknowledge_n & iow_rise;
    dma_wr        = dma_sel & iow_rise;
    flush         = cpu_wr & (reg_sel == 2'd0) & internal_data_bus[1];
    push_req      = (cpu_wr & (reg_sel == 2'd3)) | dma_wr;
    tc_hit        = dma_wr & ~terminal_count_n;
  end

  // Next-state logic for registers, FIFO, rate engine and DMA handshake.
  always_comb begin
    ior_d      = io_read_n;
    iow_d      = io_write_n;
    ws_d       = ws_q;
    dout_d     = dout_q;
    dma_en_d   = dma_en_q;
    irq_en_d   = irq_en_q;
    irq_d      = irq_q;
    overrun_d  = overrun_q;
    tc_seen_d  = tc_seen_q;
    rate_div_d = rate_div_q;
    rc_d       = rc_q;
    pending_d  = pending_q;
    sample_d   = sample_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    mem_d      = mem_q;
    rd_mux     = 8'h00;

    if (access_start) begin
      ws_d = WS_LOAD;
    end else if (ws_q != 3'd0) begin
      ws_d = ws_q - 3'd1;
    end else begin
      ws_d = 3'd0;
    end

    case (reg_sel)
      2'd0:    rd_mux = {irq_q, overrun_q, tc_seen_q, 5'(count_q)};
      2'd1:    rd_mux = rate_div_q[7:0];
      2'd2:    rd_mux = rate_div_q[15:8];
      2'd3:    rd_mux = sample_q;
      default: rd_mux = 8'h00;
    endcase
    if (cpu_rd_start) begin
      dout_d = rd_mux;
    end else begin
      dout_d = dout_q;
    end

    if (cpu_wr && (reg_sel == 2'd0)) begin
      dma_en_d = internal_data_bus[0];
      irq_en_d = internal_data_bus[2];
    end else if (cpu_wr && (reg_sel == 2'd1)) begin
      rate_div_d[7:0] = internal_data_bus;
    end else if (cpu_wr && (reg_sel == 2'd2)) begin
      rate_div_d[15:8] = internal_data_bus;
    end else begin
      rate_div_d = rate_div_q;
    end

    if (status_rd_end) begin
      irq_d = 1'b0;
    end else begin
      irq_d = irq_q;
    end
    if (tc_hit) begin
      tc_seen_d = 1'b1;
      dma_en_d  = 1'b0;
      irq_d     = irq_q | irq_en_q;
    end else begin
      tc_seen_d = tc_seen_q;
    end

    // The counter free-runs at zero while rate_div is zero, so a new rate starts on the next clock.
    if (rc_q == 16'd0) begin
      rc_d = rate_div_q;
    end else begin
      rc_d = rc_q - 16'd1;
    end
    pop_en  = (rc_q == 16'd0) && (rate_div_q != 16'd0) && (count_q != {CW{1'b0}}) && !flush;
    push_en = push_req && !flush && ((count_q != FULL_CNT) || pop_en);

    if (push_req && !flush && (count_q == FULL_CNT) && !pop_en) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_q;
    end

    if (push_en) begin
      mem_d[wptr_q] = internal_data_bus;
      wptr_d        = wptr_q + AW'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_en) begin
      sample_d = mem_q[rptr_q];
      rptr_d   = rptr_q + AW'(1);
    end else begin
      sample_d = sample_q;
    end
    strobe_d = pop_en;

    case ({push_en, pop_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (flush) begin
      wptr_d    = {AW{1'b0}};
      rptr_d    = {AW{1'b0}};
      count_d   = {CW{1'b0}};
      overrun_d = 1'b0;
      tc_seen_d = 1'b0;
    end else begin
      count_d = count_d;
    end

    // A transfer is pending from the acknowledged request until its write strobe completes.
    if (dma_wr) begin
      pending_d = 1'b0;
    end else if (dma_sel && dreq_q) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end
    dreq_d = dma_en_q && (count_q < DREQ_CNT) && !pending_q && dma_acknowledge_n;
  end

  // State registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ior_q      <= 1'b1;
      iow_q      <= 1'b1;
      ws_q       <= 3'd0;
      dout_q     <= 8'h00;
      dma_en_q   <= 1'b0;
      irq_en_q   <= 1'b0;
      irq_q      <= 1'b0;
      overrun_q  <= 1'b0;
      tc_seen_q  <= 1'b0;
      rate_div_q <= 16'd0;
      rc_q       <= 16'd0;
      dreq_q     <= 1'b0;
      pending_q  <= 1'b0;
      sample_q   <= 8'h80;
      strobe_q   <= 1'b0;
      wptr_q     <= {AW{1'b0}};
      rptr_q     <= {AW{1'b0}};
      count_q    <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      ior_q      <= ior_d;
      iow_q      <= iow_d;
      ws_q       <= ws_d;
      dout_q     <= dout_d;
      dma_en_q   <= dma_en_d;
      irq_en_q   <= irq_en_d;
      irq_q      <= irq_d;
      overrun_q  <= overrun_d;
      tc_seen_q  <= tc_seen_d;
      rate_div_q <= rate_div_d;
      rc_q       <= rc_d;
      dreq_q     <= dreq_d;
      pending_q  <= pending_d;
      sample_q   <= sample_d;
      strobe_q   <= strobe_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign data_bus_out        = dout_q;
  assign data_bus_out_enable = cpu_sel & ~io_read_n;
  assign io_channel_ready    = (ws_q == 3'd0);
  assign dma_request         = dreq_q;
  assign interrupt_request   = irq_q;
  assign sample_out          = sample_q;
  assign sample_strobe       = strobe_q;
endmodule

// File: tb/tb_isa_dma_sample_sink.sv
// Directed bench for isa_dma_sample_sink: bus cycles are driven on the falling clock edge
// and every expected value below is worked out by hand from the bus timing.
module tb_isa_dma_sample_sink;
  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic [19:0] address = 20'h0;
  logic [7:0]  internal_data_bus = 8'h00;
  logic [7:0]  data_bus_out;
  logic        data_bus_out_enable;
  logic        io_read_n = 1'b1;
  logic        io_write_n = 1'b1;
  logic        address_enable_n = 1'b1;
  logic        dma_request;
  logic        dma_acknowledge_n = 1'b1;
  logic        terminal_count_n = 1'b1;
  logic        io_channel_ready;
  logic        interrupt_request;
  logic [7:0]  sample_out;
  logic        sample_strobe;

  int vectors = 0;
  int miscompares = 0;

  isa_dma_sample_sink dut (
    .clock(clock), .reset_n(reset_n), .address(address),
    .internal_data_bus(internal_data_bus), .data_bus_out(data_bus_out),
    .data_bus_out_enable(data_bus_out_enable), .io_read_n(io_read_n),
    .io_write_n(io_write_n), .address_enable_n(address_enable_n),
    .dma_request(dma_request), .dma_acknowledge_n(dma_acknowledge_n),
    .terminal_count_n(terminal_count_n), .io_channel_ready(io_channel_ready),
    .interrupt_request(interrupt_request), .sample_out(sample_out),
    .sample_strobe(sample_strobe)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One CPU I/O cycle: strobe low for three clocks, commit on the rising strobe.
  task automatic io_cycle(input logic wr, input logic [9:0] port, input logic [7:0] wdata,
                          output logic [7:0] rdata);
    @(negedge clock);
    address = {10'h000, port};
    address_enable_n = 1'b1;
    internal_data_bus = wdata;
    if (wr) io_write_n = 1'b0;
    else io_read_n = 1'b0;
    repeat (3) @(negedge clock);
    rdata = data_bus_out;
    io_write_n = 1'b1;
    io_read_n = 1'b1;
    @(negedge clock);
    address = 20'h0;
  endtask

  task automatic cpu_wr(input logic [9:0] port, input logic [7:0] d);
    logic [7:0] unused_rd;
    io_cycle(1'b1, port, d, unused_rd);
  endtask

  task automatic cpu_rd(input logic [9:0] port, output logic [7:0] d);
    io_cycle(1'b0, port, 8'h00, d);
  endtask

  task automatic dma_xfer(input logic [7:0] d, input logic last, input logic exp_dreq);
    @(negedge clock);
    check("dreq_before_dack", {7'd0, dma_request}, {7'd0, exp_dreq});
    address_enable_n = 1'b0;
    address = 20'h12345;
    dma_acknowledge_n = 1'b0;
    internal_data_bus = d;
    terminal_count_n = ~last;
    @(negedge clock);
    check("dreq_after_dack", {7'd0, dma_request}, 8'd0);
    io_write_n = 1'b0;
    repeat (3) @(negedge clock);
    io_write_n = 1'b1;
    @(negedge clock);
    dma_acknowledge_n = 1'b1;
    terminal_count_n = 1'b1;
    address_enable_n = 1'b1;
    address = 20'h0;
  endtask

  initial begin
    logic [7:0] rd;
    int strobes;
    logic [7:0] seen [3];
    int at [3];

    #2 reset_n = 1'b0;
    #10;
    check("rst_ready", {7'd0, io_channel_ready}, 8'd1);
    check("rst_dreq", {7'd0, dma_request}, 8'd0);
    check("rst_sample", sample_out, 8'h80);
    check("rst_strobe", {7'd0, sample_strobe}, 8'd0);
    check("rst_irq", {7'd0, interrupt_request}, 8'd0);
    check("rst_dbus", data_bus_out, 8'h00);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // Status read with wait-state timing.
    @(negedge clock);
    address = 20'h002C0;
    io_read_n = 1'b0;
    @(negedge clock);
    check("ws_low1", {7'd0, io_channel_ready}, 8'd0);
    check("rd_oe", {7'd0, data_bus_out_enable}, 8'd1);
    @(negedge clock);
    check("ws_low2", {7'd0, io_channel_ready}, 8'd0);
    @(negedge clock);
    check("ws_release", {7'd0, io_channel_ready}, 8'd1);
    check("rst_status", data_bus_out, 8'h00);
    io_read_n = 1'b1;
    @(negedge clock);
    address = 20'h0;

    // Port 0x2C4 is outside the window.
    @(negedge clock);
    address = 20'h002C4;
    io_read_n = 1'b0;
    @(negedge clock);
    check("nodec_oe", {7'd0, data_bus_out_enable}, 8'd0);
    check("nodec_ready1", {7'd0, io_channel_ready}, 8'd1);
    @(negedge clock);
    check("nodec_ready2", {7'd0, io_channel_ready}, 8'd1);
    io_read_n = 1'b1;
    @(negedge clock);
    address = 20'h0;

    // Rate engine: three samples at rate_div = 4.
    cpu_wr(10'h2C3, 8'h11);
    cpu_wr(10'h2C3, 8'h22);
    cpu_wr(10'h2C3, 8'h33);
    cpu_wr(10'h2C2, 8'h00);
    check("hold_before_rate", sample_out, 8'h80);
    cpu_wr(10'h2C1, 8'h04);
    strobes = 0;
    for (int i = 0; i < 3; i++) begin
      seen[i] = 8'h00;
      at[i] = 0;
    end
    for (int i = 0; i < 22; i++) begin
      @(negedge clock);
      if (sample_strobe) begin
        if (strobes < 3) begin
          seen[strobes] = sample_out;
          at[strobes] = i;
        end
        strobes++;
      end
    end
    check("strobe_count", 8'(strobes), 8'd3);
    check("sample0", seen[0], 8'h11);
    check("sample1", seen[1], 8'h22);
    check("sample2", seen[2], 8'h33);
    check("period01", 8'(at[1] - at[0]), 8'd5);
    check("period12", 8'(at[2] - at[1]), 8'd5);
    check("sample_hold", sample_out, 8'h33);
    cpu_rd(10'h2C1, rd);
    check("rd_rate_lo", rd, 8'h04);
    cpu_rd(10'h2C3, rd);
    check("rd_sample", rd, 8'h33);
    cpu_wr(10'h2C1, 8'h00);

    // DMA: 16 transfers, TC on the last, irq enabled.
    cpu_wr(10'h2C0, 8'h05);
    check("dreq_not_yet", {7'd0, dma_request}, 8'd0);
    for (int k = 0; k < 16; k++) begin
      dma_xfer(8'hC0 + 8'(k), (k == 15), (k < 12));
    end
    check("tc_irq", {7'd0, interrupt_request}, 8'd1);
    check("tc_dreq", {7'd0, dma_request}, 8'd0);
    cpu_rd(10'h2C0, rd);
    check("dma_status", rd, 8'hB0);
    check("irq_cleared", {7'd0, interrupt_request}, 8'd0);
    cpu_rd(10'h2C0, rd);
    check("dma_status2", rd, 8'h30);
    check("dreq_after_tc", {7'd0, dma_request}, 8'd0);

    // Overrun and flush.
    cpu_wr(10'h2C0, 8'h02);
    cpu_rd(10'h2C0, rd);
    check("flush1_status", rd, 8'h00);
    for (int k = 0; k < 17; k++) cpu_wr(10'h2C3, 8'(k));
    cpu_rd(10'h2C0, rd);
    check("overrun_status", rd, 8'h50);
    cpu_wr(10'h2C0, 8'h02);
    cpu_rd(10'h2C0, rd);
    check("flush2_status", rd, 8'h00);

    // Full FIFO: rate_div = 8 pops at +1 and +10 clocks after the rate write; the
    // back-to-back pushes land at +5 (refill to 16) and +10 (push with pop while full).
    for (int k = 0; k < 16; k++) cpu_wr(10'h2C3, 8'hA0 + 8'(k));
    cpu_rd(10'h2C0, rd);
    check("full_status", rd, 8'h10);
    cpu_wr(10'h2C1, 8'h08);
    cpu_wr(10'h2C3, 8'hB0);
    cpu_wr(10'h2C3, 8'hB1);
    cpu_wr(10'h2C1, 8'h00);
    cpu_rd(10'h2C0, rd);
    check("pushpop_full_status", rd, 8'h10);
    cpu_rd(10'h2C3, rd);
    check("pushpop_sample", rd, 8'hA1);

    // Reset asserted during a wait state.
    @(negedge clock);
    address = 20'h002C1;
    io_read_n = 1'b0;
    @(negedge clock);
    check("midwait_low", {7'd0, io_channel_ready}, 8'd0);
    #2 reset_n = 1'b0;
    #1;
    check("midwait_async_ready", {7'd0, io_channel_ready}, 8'd1);
    check("midwait_sample", sample_out, 8'h80);
    io_read_n = 1'b1;
    address = 20'h0;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
